poly_sweep_ctrl: RTL

Upstream sequencer for the quadratic evaluator `Resolve`, which computes y = A·X² + B·X + C.
- On `start` it sweeps signed `x` from `x_ini` to `x_fim` in steps of `passo`.
- For each point it issues one evaluation to `Resolve` and waits for the result.
- Over the sweep it tracks min/max of y, the sample count and root crossings.
- Coefficients a, b, c are wired to `Resolve` at top level and are not handled here.

---
 rtl/poly_sweep_ctrl_pkg.sv | 18 +
 rtl/poly_sweep_ctrl_if.sv | 19 +
 rtl/poly_sweep_ctrl_stats.sv | 77 +++++++
 rtl/poly_sweep_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/poly_sweep_ctrl_pkg.sv
// Shared definitions for the quadratic sweep sequencer: state encoding and default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package poly_sweep_ctrl_pkg;

    localparam int XW_DEF      = 8;
    localparam int YW_DEF      = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ISSUE  = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_UPDATE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/poly_sweep_ctrl_if.sv
// Request/response link between the sweep sequencer and the Resolve evaluator.
// Latency: n/a (wires only).
// Backpressure: master raises inicio only while slave holds ready; valid is a one-cycle result strobe.
// Signals: inicio (request), x (signed operand), ready (evaluator idle), valid (result strobe), y (signed result).
interface poly_sweep_ctrl_if
    import poly_sweep_ctrl_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
);
    logic                 inicio;
    logic signed [XW-1:0] x;
    logic                 ready;
    logic                 valid;
    logic signed [YW-1:0] y;

    modport master (output inicio, output x, input ready, input valid, input y);
    modport slave  (input inicio, input x, output ready, output valid, output y);
endinterface

// File: rtl/poly_sweep_ctrl_stats.sv
// Sweep statistics: running min/max with first-occurrence x, sample count and root events.
// Latency: results registered on the edge where load is high.
// Backpressure: none; one sample is absorbed per load pulse.
// Ports: clk/rst, clr (restart), load (new sample), y/x (sample), ymin/ymax/xmin/xmax,
//        n_amostras, raiz_cnt, raiz_x, raiz_ok.
module poly_stats
    import poly_sweep_ctrl_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic signed [YW-1:0] y,
    input  logic signed [XW-1:0] x,
    output logic signed [YW-1:0] ymin,
    output logic signed [YW-1:0] ymax,
    output logic signed [XW-1:0] xmin,
    output logic signed [XW-1:0] xmax,
    output logic        [XW:0]   n_amostras,
    output logic        [XW:0]   raiz_cnt,
    output logic signed [XW-1:0] raiz_x,
    output logic                 raiz_ok
);

    logic                 have_prev;
    logic signed [YW-1:0] y_prev;
    logic                 sign_flip;
    logic                 root_evt;

    // A crossing needs two nonzero neighbours of opposite sign; a zero
    // sample is itself the root, so it must not also count as a flip
    // on either side.
    always_comb begin
        sign_flip = have_prev && (y_prev != '0) && (y != '0) &&
                    (y_prev[YW-1] != y[YW-1]);
        root_evt  = (y == '0) || sign_flip;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ymin       <= '0;
            ymax       <= '0;
            xmin       <= '0;
            xmax       <= '0;
            n_amostras <= '0;
            raiz_cnt   <= '0;
            raiz_x     <= '0;
            raiz_ok    <= 1'b0;
            have_prev  <= 1'b0;
            y_prev     <= '0;
        end else if (load) begin
            n_amostras <= n_amostras + (XW+1)'(1);
            // Strict compares so a later tie keeps the earlier x.
            if (!have_prev || (y < ymin)) begin
                ymin <= y;
                xmin <= x;
            end
            if (!have_prev || (y > ymax)) begin
                ymax <= y;
                xmax <= x;
            end
            if (root_evt) begin
                raiz_cnt <= raiz_cnt + (XW+1)'(1);
                if (!raiz_ok) begin
                    raiz_x  <= x;
                    raiz_ok <= 1'b1;
                end
            end
            y_prev    <= y;
            have_prev <= 1'b1;
        end
    end

endmodule

// File: rtl/poly_sweep_ctrl.sv
// Sweeps signed x from x_ini to x_fim by passo, evaluating each point through Resolve and tracking stats.
// Latency: first request one cycle after start; 3 cycles per point plus Resolve latency; done one cycle after last update.
// Backpressure: a request waits in ISSUE until sol.ready; each point gives up after TIMEOUT cycles without sol.valid.
// Ports: clk/rst, start/x_ini/x_fim/passo (sweep setup), sol (master link to Resolve), busy/done,
//        ymin/ymax/xmin/xmax, n_amostras, raiz_cnt/raiz_x/raiz_ok, err_range/err_timeout.
module poly_sweep_ctrl
    import poly_sweep_ctrl_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int YW      = YW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [XW-1:0] x_ini,
    input  logic signed [XW-1:0] x_fim,
    input  logic        [XW-1:0] passo,
    poly_sweep_ctrl_if.master    sol,
    output logic                 busy,
    output logic                 done,
    output logic signed [YW-1:0] ymin,
    output logic signed [YW-1:0] ymax,
    output logic signed [XW-1:0] xmin,
    output logic signed [XW-1:0] xmax,
    output logic        [XW:0]   n_amostras,
    output logic        [XW:0]   raiz_cnt,
    output logic signed [XW-1:0] raiz_x,
    output logic                 raiz_ok,
    output logic                 err_range,
    output logic                 err_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state;
    logic signed [XW-1:0] x_cur;
    logic signed [XW-1:0] x_fim_r;
    logic        [XW-1:0] passo_r;
    logic        [TW-1:0] to_cnt;
    logic signed [YW-1:0] y_lat;
    logic                 range_hold;

    logic                 issue_go;
    logic                 start_acc;
    logic                 stats_load;
    logic signed [XW+1:0] x_nxt;
    logic signed [XW+1:0] x_fim_ext;

    // Two guard bits keep x_cur + passo exact, so a step past the top of
    // the signed range ends the sweep instead of wrapping negative.
    always_comb begin
        issue_go   = (state == ST_ISSUE) && sol.ready;
        start_acc  = (state == ST_IDLE) && start && !range_hold;
        stats_load = (state == ST_UPDATE);
        x_nxt      = $signed({{2{x_cur[XW-1]}}, x_cur}) + $signed({2'b00, passo_r});
        x_fim_ext  = $signed({{2{x_fim_r[XW-1]}}, x_fim_r});
    end

    assign sol.inicio = issue_go;
    assign sol.x      = x_cur;
    assign busy       = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_UPDATE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            x_cur       <= '0;
            x_fim_r     <= '0;
            passo_r     <= '0;
            to_cnt      <= '0;
            y_lat       <= '0;
            range_hold  <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A bad range is flagged at capture and reported one
                    // idle cycle later, so done lands two cycles after start
                    // and start stays blocked in between.
                    if (range_hold) begin
                        range_hold <= 1'b0;
                        state      <= ST_DONE;
                    end else if (start) begin
                        x_cur       <= x_ini;
                        x_fim_r     <= x_fim;
                        passo_r     <= (passo == '0) ? XW'(1) : passo;
                        err_range   <= 1'b0;
                        err_timeout <= 1'b0;
                        if (x_ini > x_fim) begin
                            err_range  <= 1'b1;
                            range_hold <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_go) begin
                        to_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sol.valid) begin
                        y_lat <= sol.y;
                        state <= ST_UPDATE;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_UPDATE: begin
                    if (x_nxt > x_fim_ext) begin
                        state <= ST_DONE;
                    end else begin
                        x_cur <= x_nxt[XW-1:0];
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    poly_stats #(
        .XW (XW),
        .YW (YW)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .load       (stats_load),
        .y          (y_lat),
        .x          (x_cur),
        .ymin       (ymin),
        .ymax       (ymax),
        .xmin       (xmin),
        .xmax       (xmax),
        .n_amostras (n_amostras),
        .raiz_cnt   (raiz_cnt),
        .raiz_x     (raiz_x),
        .raiz_ok    (raiz_ok)
    );

endmodule
